// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with DEPTH stages.
// Empty slots collapse, so a full pipe keeps one transfer per cycle.
// out_valid/out_data come straight from flops. Emptied or flushed stages
// reload BUBBLE so the output bus is defined when nothing is valid.
module pipe_stage_reg #(
  parameter int              WIDTH  = 32,
  parameter int              DEPTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [2:0]       occupancy
);

  localparam int         LAST      = DEPTH - 1;
  localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

  // Per-stage state: a valid bit and a payload register.
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // advance[k]: stage k hands its payload onward at the coming edge.
  logic [DEPTH-1:0] advance;
  logic             accept;
  logic             consume;

  logic [2:0] occ_q;
  logic [2:0] occ_d;

  // Advance chain, computed from the output end backwards. A stage moves
  // when the next stage is empty or is moving itself, so holes close up.
  // Flush blocks the consume, so downstream never sees a transfer in a
  // flush cycle.
  always_comb begin
    // NOTE: each signal an always_comb writes gets a default value first.
    // Otherwise a path that skips the assignment infers a latch.
    advance       = '0;
    advance[LAST] = valid_q[LAST] & out_ready & ~flush;
    for (int k = LAST - 1; k >= 0; k--) begin
      advance[k] = valid_q[k] & (~valid_q[k+1] | advance[k+1]);
    end
  end

  // Handshake decode. in_ready depends only on stage state, out_ready and
  // flush, and never on in_valid, so no loop forms through upstream.
  always_comb begin
    in_ready = ~flush & (~valid_q[0] | advance[0]);
    accept   = in_valid & in_ready;
    consume  = advance[LAST];
  end

  // Stage next-state. Each stage does one of three things: it fills from
  // its predecessor (or from in_data for S0), it drains to BUBBLE, or it
  // holds its payload. Flush empties every stage.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
    end

    if (accept) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
    end else if (advance[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = BUBBLE;
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (advance[k-1]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_q[k-1];
      end else if (advance[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = BUBBLE;
      end
    end

    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        data_d[k]  = BUBBLE;
      end
    end
  end

  // Occupancy next-state. It tracks accepts minus consumes, stays inside
  // 0..DEPTH, and clears on flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !consume) begin
      occ_d = (occ_q == DEPTH_CNT) ? occ_q : occ_q + 3'd1;
    end else if (!accept && consume) begin
      occ_d = (occ_q == 3'd0) ? occ_q : occ_q - 3'd1;
    end
  end

  // State registers with synchronous reset. Reset overrides flush and any
  // transfer in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples its pre-edge value, whatever the statement order.
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      // NOTE: the payload registers are reset as well as the valid bits.
      // out_data must read BUBBLE after reset, not stale or X contents.
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= BUBBLE;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Outputs come directly from the last stage and the occupancy counter.
  always_comb begin
    out_valid = valid_q[LAST];
    out_data  = data_q[LAST];
    occupancy = occ_q;
  end

endmodule
